reg_dump_reader: RTL and testbench
==================================

// Module: reg_dump_reader
// PURPOSE
//  Sequential reader for the 32x64 integer register file. On start it walks
//  x0..x31 through one regfile read port and streams each (index, value) pair
//  out on a valid/ready channel to the difftest/trace logic.
//  Sits beside the regfile: drives readReg-style address, consumes readData.
// PARAMETERS
//  NUM_REGS  32  registers walked, index 0..NUM_REGS-1
//  ADDR_W    5   register index width, $clog2(NUM_REGS)
//  DATA_W    64  register width
// PORTS
//  clk        in   1       clock, all state on posedge
//  rst_n      in   1       asynchronous, active-low reset
//  start      in   1       begin a dump; honoured only in IDLE
//  abort      in   1       synchronous flush to IDLE; no done pulse
//  busy       out  1       high from cycle after accepted start until IDLE
//  done       out  1       one-cycle pulse after the final beat completes
//  rd_addr    out  ADDR_W  regfile read address (combinational read port)
//  rd_data    in   DATA_W  regfile read data for rd_addr, same cycle
//  out_valid  out  1       beat valid
//  out_ready  in   1       consumer accepts beat when valid && ready
//  out_idx    out  ADDR_W  register index of beat
//  out_data   out  DATA_W  register value of beat
// BEHAVIOUR
//  Reset (async, rst_n=0): state IDLE, idx=0. busy, done, out_valid=0.
//  rd_addr, out_idx, out_data=0.
//  FSM states: IDLE, READ, SEND, DONE.
//  IDLE: start=1 -> READ, idx=0. start=0 -> stay.
//  READ: rd_addr=idx. On this edge, rd_data->out_data and idx->out_idx.
//   out_valid=1. Next state is SEND.
//  SEND: out_valid held at 1. out_idx and out_data stay stable until handshake.
//   On handshake, last idx (NUM_REGS-1) -> DONE. Otherwise idx+1 -> READ.
//   On handshake, out_valid drops the next cycle.
//  DONE: done=1 for exactly one cycle, then IDLE. busy=0 in IDLE only.
//  Latency: start edge -> out_valid 2 cycles later. Beat period >= 2 cycles.
//  Snapshot: each value is the regfile content in its READ cycle.
//   A write to register k is visible iff it lands before k's READ edge.
//  Boundaries:
//   - start while busy: ignored.
//   - abort in any state (wins over start and handshake): IDLE next cycle,
//     out_valid=0, no done pulse.
//   - out_ready held 0: stall indefinitely in SEND, no data change.
//   - idx never wraps; the counter saturates at NUM_REGS-1.
//   - start in the DONE cycle: ignored (not IDLE yet).
// CONFIGURATION
//  REG_DUMP_SKIP_ZERO_EN defined: a zero rd_data in READ emits no beat.
//   Non-last idx -> idx+1 and stay in READ. Last idx -> DONE.
//   x0 is never emitted. All-zero file -> done with zero beats.
//  Undefined: every register emits exactly one beat, NUM_REGS beats per dump.
// STRUCTURE
//  common package:
//   - reg_dump_state_t enum {IDLE, READ, SEND, DONE}
//   - REG_NUM=32 and REG_ADDR_W=5 constants
//   - reg_dump_beat_t struct {idx, data} for the out_* channel
//  Single module, no sub-module; idx counter and FSM inline.
// TESTING
//  1 Reset: rst_n=0 mid-SEND -> out_valid, busy, done=0 immediately; IDLE after.
//  2 Full dump, ready=1, x[k]=k*0x1111 -> 32 beats, idx 0..31 in order, values
//    match; first valid 2 cycles after start; done pulses once, 65 cycles after
//    start; busy then drops.
//  3 Backpressure: ready=0 for 10 cycles on beat 5 -> idx=5, data stable, valid
//    held; dump completes with 32 beats total.
//  4 Abort: abort at beat 12 -> valid=0 next cycle, no done. New start -> beat
//    idx=0.
//  5 Start while busy at beat 3 -> ignored; beat count stays 32; one done.
//  6 SKIP_ZERO_EN: only x1=0xA and x31=0xB nonzero -> 2 beats (1,0xA),(31,0xB),
//    then done. All-zero file -> 0 beats, done. Without the macro -> 32 beats.

Source files
------------

// File: rtl/reg_dump_reader_pkg.sv
// Shared types and sizing for the integer register-file dump reader.
package reg_dump_reader_pkg;

  localparam int REG_NUM    = 32;
  localparam int REG_ADDR_W = 5;
  localparam int REG_DATA_W = 64;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    SEND,
    DONE
  } reg_dump_state_t;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] idx;
    logic [REG_DATA_W-1:0] data;
  } reg_dump_beat_t;

endpackage

// File: rtl/reg_dump_reader_if.sv
// Beat channel from the dump reader to the difftest/trace consumer.
interface reg_dump_reader_if;
  import reg_dump_reader_pkg::*;

  // A beat transfers on a clock edge where out_valid && out_ready. Once raised,
  // out_valid stays high and out_idx/out_data stay stable until that transfer.
  logic                  out_valid;
  logic                  out_ready;
  logic [REG_ADDR_W-1:0] out_idx;
  logic [REG_DATA_W-1:0] out_data;

  modport master (output out_valid, output out_idx, output out_data, input out_ready);
  modport slave  (input out_valid, input out_idx, input out_data, output out_ready);

endinterface

// File: rtl/reg_dump_reader.sv
// Walks x0..x31 through one combinational regfile read port and streams (idx, value) beats.
// Optional macro REG_DUMP_SKIP_ZERO_EN: zero-valued registers (and x0) emit no beat.
module reg_dump_reader
  import reg_dump_reader_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic [REG_ADDR_W-1:0] rd_addr,
  input  logic [REG_DATA_W-1:0] rd_data,
  reg_dump_reader_if.master     out_if,
  output reg_dump_state_t       dbg_state
);

  localparam logic [REG_ADDR_W-1:0] LAST_IDX = REG_ADDR_W'(REG_NUM - 1);

  reg_dump_state_t       r_state;
  logic [REG_ADDR_W-1:0] r_idx;
  reg_dump_beat_t        r_beat;
  logic                  r_valid;
  logic                  r_busy;
  logic                  r_done;

  logic w_last;
  logic w_skip;

  assign w_last = (r_idx == LAST_IDX);

`ifdef REG_DUMP_SKIP_ZERO_EN
  assign w_skip = (rd_data == '0) || (r_idx == '0);
`else
  assign w_skip = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_idx   <= '0;
      r_beat  <= '0;
      r_valid <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (abort) begin
        r_state <= IDLE;
        r_idx   <= '0;
        r_valid <= 1'b0;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (start) begin
              r_state <= READ;
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end
          end
          READ: begin
            // Snapshot taken here: the value present during this READ cycle is what streams out.
            if (w_skip) begin
              if (w_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_idx <= r_idx + 1'b1;
              end
            end else begin
              r_beat.idx  <= r_idx;
              r_beat.data <= rd_data;
              r_valid     <= 1'b1;
              r_state     <= SEND;
            end
          end
          SEND: begin
            if (out_if.out_ready) begin
              r_valid <= 1'b0;
              if (w_last) begin
                r_state <= DONE;
                r_done  <= 1'b1;
              end else begin
                r_idx   <= r_idx + 1'b1;
                r_state <= READ;
              end
            end
          end
          DONE: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
          end
          default: begin
            r_state <= IDLE;
            r_busy  <= 1'b0;
            r_valid <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rd_addr         = r_idx;
  assign busy            = r_busy;
  assign done            = r_done;
  assign out_if.out_valid = r_valid;
  assign out_if.out_idx  = r_beat.idx;
  assign out_if.out_data = r_beat.data;
  assign dbg_state       = r_state;

endmodule

// File: tb/tb_reg_dump_reader.sv
// Bench for reg_dump_reader: randomized register contents and ready, checked against a dump model.
module tb_reg_dump_reader;
  import reg_dump_reader_pkg::*;

  localparam int BW = REG_ADDR_W + REG_DATA_W;
`ifdef REG_DUMP_SKIP_ZERO_EN
  localparam bit SKIP_EN = 1'b1;
`else
  localparam bit SKIP_EN = 1'b0;
`endif

  logic                  clk;
  logic                  rst_n;
  logic                  start;
  logic                  abort;
  logic                  busy;
  logic                  done;
  logic [REG_ADDR_W-1:0] rd_addr;
  logic [REG_DATA_W-1:0] rd_data;
  reg_dump_state_t       dbg_state;

  logic [REG_DATA_W-1:0] regs [REG_NUM];
  logic [BW-1:0]         exp_q[$];
  int                    exp_n;
  int                    n_checks = 0;
  int                    n_errors = 0;
  int                    n_beats  = 0;
  int                    n_done   = 0;
  bit                    rand_ready = 1'b0;

  reg_dump_reader_if u_if();

  reg_dump_reader dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .busy      (busy),
    .done      (done),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .out_if    (u_if),
    .dbg_state (dbg_state)
  );

  assign rd_data = regs[rd_addr];

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // reference model: which registers produce a beat, and when things happen with ready held high
  function automatic bit emitted(input int k);
    return !SKIP_EN || (k != 0 && regs[k] != '0);
  endfunction

  function automatic void load_expected();
    exp_q.delete();
    exp_n = 0;
    for (int k = 0; k < REG_NUM; k++) begin
      if (emitted(k)) begin
        exp_q.push_back({REG_ADDR_W'(k), regs[k]});
        exp_n++;
      end
    end
  endfunction

  function automatic int emitted_before(input int n);
    int c = 0;
    for (int k = 0; k < n; k++) if (emitted(k)) c++;
    return c;
  endfunction

  function automatic int first_valid_cycle();
    int c = 1;
    for (int k = 0; k < REG_NUM; k++) begin
      if (emitted(k)) return c + 1;
      c++;
    end
    return -1;
  endfunction

  function automatic int done_cycle();
    int c = 1;
    for (int k = 0; k < REG_NUM; k++) c += emitted(k) ? 2 : 1;
    return c;
  endfunction

  // scoreboard / monitor
  always @(negedge clk) begin
    if (rst_n === 1'b1 && u_if.out_valid === 1'b1 && u_if.out_ready === 1'b1) begin
      n_beats++;
      if (exp_q.size() == 0) check("beat_unexpected", {u_if.out_idx, u_if.out_data}, '0);
      else                   check("beat", {u_if.out_idx, u_if.out_data}, exp_q.pop_front());
    end
    if (done === 1'b1) n_done++;
  end

  // driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_ready) u_if.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic rand_regs();
    for (int k = 0; k < REG_NUM; k++)
      regs[k] = ($urandom_range(0, 3) == 0) ? '0 : {$urandom, $urandom};
  endtask

  task automatic kick();
    load_expected();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input int c0, output int cyc);
    cyc = c0;
    while (done !== 1'b1 && cyc < 3000) begin
      tick();
      cyc++;
    end
    check("done_seen", done, 1'b1);
  endtask

  task automatic wait_beat(input int k);
    int n = 0;
    while (!(u_if.out_valid === 1'b1 && u_if.out_idx == REG_ADDR_W'(k)) && n < 500) begin
      tick();
      n++;
    end
    check("reach_beat", {u_if.out_valid, u_if.out_idx}, {1'b1, REG_ADDR_W'(k)});
  endtask

  task automatic finish_dump(input string tag, input int b0, input int d0);
    check({tag, "_beats"}, n_beats - b0, exp_n);
    check({tag, "_done_cnt"}, n_done - d0, 1);
    check({tag, "_q_empty"}, exp_q.size(), 0);
    check({tag, "_idle"}, dbg_state, IDLE);
  endtask

  initial begin
    int cyc, b0, d0, stable, wrong;
    logic [REG_DATA_W-1:0] v;
    rst_n = 1'b0;
    start = 1'b0;
    abort = 1'b0;
    u_if.out_ready = 1'b0;
    for (int k = 0; k < REG_NUM; k++) regs[k] = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // reset values
    check("rst_busy", busy, 1'b0);
    check("rst_done", done, 1'b0);
    check("rst_valid", u_if.out_valid, 1'b0);
    check("rst_rd_addr", rd_addr, 0);
    check("rst_out_idx", u_if.out_idx, 0);
    check("rst_out_data", u_if.out_data, 0);
    check("rst_state", dbg_state, IDLE);

    // full dump, ready high, x[k] = k*0x1111
    for (int k = 0; k < REG_NUM; k++) regs[k] = 64'(k) * 64'h1111;
    u_if.out_ready = 1'b1;
    b0 = n_beats; d0 = n_done;
    kick();
    check("busy_after_start", busy, 1'b1);
    check("valid_cycle1", u_if.out_valid, 1'b0);
    cyc = 1;
    while (u_if.out_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    check("first_valid_lat", cyc, first_valid_cycle());
    wait_done(cyc, cyc);
    check("done_lat", cyc, done_cycle());
    tick();
    check("done_one_cycle", done, 1'b0);
    check("busy_drop", busy, 1'b0);
    check("idx_saturate", rd_addr, REG_NUM - 1);
    finish_dump("full", b0, d0);

    // backpressure on beat 5
    rand_regs();
    regs[5] = regs[5] | 64'h1;
    b0 = n_beats; d0 = n_done;
    kick();
    wait_beat(5);
    u_if.out_ready = 1'b0;
    stable = 1;
    repeat (10) begin
      tick();
      if (!(u_if.out_valid === 1'b1 && u_if.out_idx == 5 && u_if.out_data == regs[5])) stable = 0;
    end
    check("stall_stable", stable, 1);
    check("stall_busy", busy, 1'b1);
    u_if.out_ready = 1'b1;
    wait_done(0, cyc);
    tick();
    finish_dump("bp", b0, d0);

    // abort at beat 12
    rand_regs();
    regs[12] = regs[12] | 64'h1;
    b0 = n_beats; d0 = n_done;
    kick();
    wait_beat(12);
    abort = 1'b1;
    u_if.out_ready = 1'b0;
    tick();
    abort = 1'b0;
    check("abort_valid", u_if.out_valid, 1'b0);
    check("abort_busy", busy, 1'b0);
    check("abort_state", dbg_state, IDLE);
    u_if.out_ready = 1'b1;
    repeat (5) tick();
    check("abort_no_done", n_done - d0, 0);
    check("abort_beats", n_beats - b0, emitted_before(12));
    exp_q.delete();

    // restart after abort with random ready; writes land before x20's READ and after x2's
    rand_regs();
    regs[2]  = regs[2] | 64'h1;
    regs[5]  = regs[5] | 64'h1;
    regs[20] = regs[20] | 64'h1;
    b0 = n_beats; d0 = n_done;
    kick();
    cyc = 1;
    while (u_if.out_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    check("restart_first_idx", u_if.out_idx, exp_q[0][BW-1:REG_DATA_W]);
    rand_ready = 1'b1;
    wait_beat(5);
    v = {$urandom, $urandom} | 64'h1;
    regs[2]  = ~regs[2] | 64'h1;
    regs[20] = v;
    foreach (exp_q[i]) if (exp_q[i][BW-1:REG_DATA_W] == 20) exp_q[i][REG_DATA_W-1:0] = v;
    wait_done(0, cyc);
    rand_ready = 1'b0;
    u_if.out_ready = 1'b1;
    tick();
    finish_dump("snap", b0, d0);

    // start while busy at beat 3, and start during the DONE cycle
    rand_regs();
    regs[3] = regs[3] | 64'h1;
    b0 = n_beats; d0 = n_done;
    kick();
    wait_beat(3);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done(0, cyc);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_in_done_busy", busy, 1'b0);
    tick();
    check("start_in_done_idle", dbg_state, IDLE);
    check("start_in_done_valid", u_if.out_valid, 1'b0);
    finish_dump("busy_start", b0, d0);

    // sparse file: only x1 and x31 nonzero
    for (int k = 0; k < REG_NUM; k++) regs[k] = '0;
    regs[1]  = 64'hA;
    regs[31] = 64'hB;
    rand_ready = 1'b1;
    b0 = n_beats; d0 = n_done;
    kick();
    wait_done(0, cyc);
    tick();
    check("sparse_count", n_beats - b0, SKIP_EN ? 2 : 32);
    finish_dump("sparse", b0, d0);

    // all-zero file
    regs[1]  = '0;
    regs[31] = '0;
    b0 = n_beats; d0 = n_done;
    kick();
    wait_done(0, cyc);
    tick();
    check("zero_count", n_beats - b0, SKIP_EN ? 0 : 32);
    finish_dump("zero", b0, d0);

    // random dumps with random ready
    for (int r = 0; r < 3; r++) begin
      rand_regs();
      b0 = n_beats; d0 = n_done;
      kick();
      wait_done(0, cyc);
      tick();
      finish_dump("rand", b0, d0);
    end
    rand_ready = 1'b0;

    // asynchronous reset while stalled in SEND
    rand_regs();
    regs[4] = regs[4] | 64'h1;
    u_if.out_ready = 1'b0;
    kick();
    cyc = 0;
    while (u_if.out_valid !== 1'b1 && cyc < 100) begin tick(); cyc++; end
    check("pre_rst_valid", u_if.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid", u_if.out_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    check("arst_done", done, 1'b0);
    #2 rst_n = 1'b1;
    tick();
    check("arst_state", dbg_state, IDLE);
    check("arst_idx", rd_addr, 0);
    exp_q.delete();
    wrong = 0;
    repeat (3) begin
      tick();
      if (busy !== 1'b0 || u_if.out_valid !== 1'b0) wrong++;
    end
    check("arst_stays_idle", wrong, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
